// File: rtl/clk_div.sv
// Programmable integer clock divider: glitch-free divided clock plus a period tick.
// Divisor updates and run/stop decisions only land on period boundaries.
module clk_div #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_valid_i,
   output logic             div_ready_o,
   output logic [DIV_W-1:0] div_act_o,
   output logic             clk_o,
   output logic             tick_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_q, act_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             boundary, apply, accept;

   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
      return (v < DIV_W'(2)) ? DIV_W'(2) : v;
   endfunction

   // High for the first ceil(N/2) counts; one extra bit keeps N=2^DIV_W-1 safe.
   function automatic logic in_high_phase(input logic [DIV_W-1:0] cnt,
                                          input logic [DIV_W-1:0] n);
      logic [DIV_W:0] half;
      half = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
      return ({1'b0, cnt} < half);
   endfunction

   assign boundary = (state_q == RUN) && (cnt_q == act_q - DIV_W'(1));
   assign apply    = (state_q == IDLE) || boundary;
   assign accept   = div_valid_i && !pend_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_div_d = pend_div_q;

      case (state_q)
         IDLE: begin
            if (en_i) state_d = RUN;
         end
         RUN: begin
            if (boundary) begin
               if (!en_i) state_d = IDLE;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A parked divisor has priority; ready is low while one is parked.
      if (apply) begin
         if (pend_q) begin
            act_d  = pend_div_q;
            pend_d = 1'b0;
         end else if (accept) begin
            act_d = clamp_div(div_i);
         end
      end else if (accept) begin
         pend_d     = 1'b1;
         pend_div_d = clamp_div(div_i);
      end

      // Registered from next-state values so the flop output follows the count directly.
      clk_d = (state_d == RUN) && in_high_phase(cnt_d, act_d);
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         act_q   <= DEF_DIV;
         pend_q  <= 1'b0;
         clk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
      end
   end

   // Parked divisor is qualified by pend_q, so it carries no reset.
   always_ff @(posedge clk_i) begin
      pend_div_q <= pend_div_d;
   end

   assign div_ready_o = !pend_q;
   assign div_act_o   = act_q;
   assign clk_o       = clk_q;
   assign tick_o      = boundary;

endmodule
